// File: rtl/shift_add_seq_pkg.sv
// Shared types and constants for the shift-add constant-multiply sequencer.
// Each recipe is a short list of shift-and-add steps whose result equals x*K.
package shift_add_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ADD_X   = 2'd0,
      SUB_X   = 2'd1,
      ADD_ACC = 2'd2
   } op_t;

   typedef struct packed {
      op_t        op;
      logic [2:0] shift;
      logic       last;
   } step_t;

   localparam int unsigned K0 = 32'd707;
   localparam int unsigned K1 = 32'd711;

   // 707 = ((((x<<2)+x)<<1)+x)<<5 ... evaluated step by step
   localparam step_t RECIPE_707 [4] = '{
      '{ADD_X, 3'd2, 1'b0},
      '{ADD_X, 3'd1, 1'b0},
      '{ADD_X, 3'd5, 1'b0},
      '{ADD_X, 3'd1, 1'b1}
   };

   // 711: 5x, then 80x-x = 79x, then 632x+79x = 711x
   localparam step_t RECIPE_711 [3] = '{
      '{ADD_X,   3'd2, 1'b0},
      '{SUB_X,   3'd4, 1'b0},
      '{ADD_ACC, 3'd3, 1'b1}
   };

   // Select the current step for a requester; the short recipe clamps to its last step.
   function automatic step_t recipe_step(input logic id, input logic [1:0] idx);
      step_t s;
      s = RECIPE_711[2];
      if (id == 1'b0) begin
         s = RECIPE_707[idx];
      end else begin
         case (idx)
            2'd0:    s = RECIPE_711[0];
            2'd1:    s = RECIPE_711[1];
            default: s = RECIPE_711[2];
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/shift_add_alu.sv
// Combinational shift-add step: next acc from (acc, x, op, shift), modulo 2^WIDTH.
module shift_add_alu
   import shift_add_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] x,
   input  op_t              op,
   input  logic [2:0]       shift,
   output logic [WIDTH-1:0] acc_next
);

   logic [WIDTH-1:0] shifted;

   // Shift the accumulator, then add/subtract x or add the unshifted accumulator.
   always_comb begin
      shifted = acc << shift;
      case (op)
         ADD_X:   acc_next = shifted + x;
         SUB_X:   acc_next = shifted - x;
         ADD_ACC: acc_next = shifted + acc;
         default: acc_next = shifted;
      endcase
   end

endmodule

// File: rtl/shift_add_sequencer.sv
// Two-requester constant multiplier (x*707 for req0, x*711 for req1) using
// one shared shift-add step unit and round-robin arbitration.
// Optional self-check output chk_err is built when SHIFT_ADD_SEQ_CHECK_EN is defined.
module shift_add_sequencer
   import shift_add_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id,
   output logic             busy
`ifdef SHIFT_ADD_SEQ_CHECK_EN
   ,
   output logic             chk_err
`endif
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] x_reg;
   logic             id;
   logic [1:0]       idx;
   logic             last_grant;
   logic             grant;
   logic             accept;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] alu_next;
   step_t            cur_step;

   assign cur_step = recipe_step(id, idx);
   assign rsp_data = acc;
   assign rsp_id   = id;

   shift_add_alu #(.WIDTH(WIDTH)) u_alu (
      .acc      (acc),
      .x        (x_reg),
      .op       (cur_step.op),
      .shift    (cur_step.shift),
      .acc_next (alu_next)
   );

   // Round-robin pick: on contention favour the requester not granted last.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end else if (req1_valid) begin
         grant = 1'b1;
      end else begin
         grant = 1'b0;
      end
   end

   // Ready only in IDLE (and never under reset), only for the granted requester.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst && state == ST_IDLE) begin
         req0_ready = req0_valid && !grant;
         req1_ready = req1_valid && grant;
      end else begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
      end
   end

   assign accept  = req0_ready | req1_ready;
   assign in_data = grant ? req1_data : req0_data;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status outputs.
   always_comb begin
      state_next = state;
      rsp_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (accept) begin
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cur_step.last) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_RUN;
            end
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_DONE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: capture operand on accept, step the accumulator while running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= {WIDTH{1'b0}};
         x_reg      <= {WIDTH{1'b0}};
         id         <= 1'b0;
         idx        <= 2'd0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  x_reg      <= in_data;
                  acc        <= in_data;
                  id         <= grant;
                  idx        <= 2'd0;
                  last_grant <= grant;
               end
            end
            ST_RUN: begin
               acc <= alu_next;
               idx <= idx + 2'd1;
            end
            default: begin
               acc <= acc;
            end
         endcase
      end
   end

`ifdef SHIFT_ADD_SEQ_CHECK_EN
   logic [WIDTH-1:0] expected;

   // Reference product for the job currently held.
   always_comb begin
      expected = id ? (x_reg * WIDTH'(K1)) : (x_reg * WIDTH'(K0));
   end

   // Sticky flag: any presented result that disagrees with x*K.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_err <= 1'b0;
      end else if (rsp_valid && (rsp_data != expected)) begin
         chk_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_shift_add_sequencer.sv
// Self-checking bench: transaction-level model (x*K, fixed latency, round-robin)
// checked every cycle, plus directed cases with literal expectations.
module tb_shift_add_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0;
   logic        req0_ready;
   logic [31:0] req0_data = 32'd0;
   logic        req1_valid = 1'b0;
   logic        req1_ready;
   logic [31:0] req1_data = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic        rsp_id;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   shift_add_sequencer #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_data  (req0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_data  (req1_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // ---------------- behavioural model, checked every cycle ----------------
   bit          m_busy = 1'b0;
   bit          m_last = 1'b1;
   int          m_cnt  = 0;
   int          m_lat  = 0;
   logic [31:0] m_exp  = 32'd0;
   logic        m_id   = 1'b0;

   // Compare DUT against the model each cycle, then advance the model.
   always @(negedge clk) begin
      bit done;
      bit er0;
      bit er1;
      if (rst) begin
         chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
         chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
         chk("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
         chk("rst_busy",       {31'd0, busy},       32'd0);
         chk("rst_rsp_data",   rsp_data,            32'd0);
         chk("rst_rsp_id",     {31'd0, rsp_id},     32'd0);
         m_busy = 1'b0;
         m_last = 1'b1;
      end else begin
         if (m_busy) m_cnt++;
         done = m_busy && (m_cnt >= m_lat);
         er0  = !m_busy && req0_valid && (!req1_valid || m_last == 1'b1);
         er1  = !m_busy && req1_valid && (!req0_valid || m_last == 1'b0);
         chk("req0_ready", {31'd0, req0_ready}, {31'd0, er0});
         chk("req1_ready", {31'd0, req1_ready}, {31'd0, er1});
         chk("busy",       {31'd0, busy},       {31'd0, m_busy});
         chk("rsp_valid",  {31'd0, rsp_valid},  {31'd0, done});
         if (done) begin
            chk("rsp_data", rsp_data, m_exp);
            chk("rsp_id",   {31'd0, rsp_id}, {31'd0, m_id});
         end
         if (done && rsp_ready) begin
            m_busy = 1'b0;
         end else if (er0 || er1) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_id   = er1;
            m_last = er1;
            m_exp  = er1 ? req1_data * 32'd711 : req0_data * 32'd707;
            m_lat  = er1 ? 4 : 5;
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic settle();
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   // One request alone; checks data, id and latency counted from the accept cycle.
   task automatic run_single(input bit which, input logic [31:0] xv,
                             input logic [31:0] exp_data, input int exp_lat);
      bit got;
      int lat;
      got = 1'b0;
      lat = 0;
      if (which) begin req1_valid = 1'b1; req1_data = xv; end
      else       begin req0_valid = 1'b1; req0_data = xv; end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((which ? req1_ready : req0_ready) == 1'b1) begin got = 1'b1; break; end
      end
      if (!got) timeout("accept_wait");
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      got = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rsp_valid) begin got = 1'b1; lat = i; break; end
      end
      if (!got) begin
         timeout("rsp_wait");
      end else begin
         chk("lit_latency", lat, exp_lat);
         chk("lit_data", rsp_data, exp_data);
         chk("lit_id", {31'd0, rsp_id}, {31'd0, which});
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] held_data;
      logic        held_id;
      logic [31:0] seen_data [4];
      logic        seen_id [4];
      int          nseen;
      bit          got;

      // Both requesters valid from reset, x=3: expect 0,1,0,1 with 2121/2133.
      req0_valid = 1'b1; req0_data = 32'd3;
      req1_valid = 1'b1; req1_data = 32'd3;
      rsp_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      nseen = 0;
      for (int i = 0; i < 60 && nseen < 4; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen_data[nseen] = rsp_data;
            seen_id[nseen]   = rsp_id;
            nseen++;
         end
      end
      if (nseen < 4) timeout("alternate_wait");
      for (int i = 0; i < nseen; i++) begin
         chk("alt_id",   {31'd0, seen_id[i]}, (i % 2 == 0) ? 32'd0 : 32'd1);
         chk("alt_data", seen_data[i],        (i % 2 == 0) ? 32'd2121 : 32'd2133);
      end
      settle();

      run_single(1'b0, 32'd1, 32'd707, 5);
      settle();
      run_single(1'b1, 32'd10, 32'd7110, 4);
      settle();
      run_single(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FD39, 4);
      settle();

      // Back-pressure: result held for 10 cycles with a competing valid present.
      rsp_ready = 1'b0;
      run_single(1'b0, 32'd5, 32'd3535, 5);
      held_data = rsp_data;
      held_id   = rsp_id;
      @(posedge clk); #1;
      req1_valid = 1'b1;
      req1_data  = 32'd77;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_data",  rsp_data, held_data);
         chk("hold_id",    {31'd0, rsp_id}, {31'd0, held_id});
         chk("hold_busy",  {31'd0, busy}, 32'd1);
         chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      end
      req1_valid = 1'b0;
      settle();

      // Reset mid-RUN after a req0 grant: pointer must return to favour req0.
      req0_valid = 1'b1; req0_data = 32'd7;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req0_ready) begin got = 1'b1; break; end
      end
      if (!got) timeout("rst_accept_wait");
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_data = 32'd9;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstrun_outputs", {rsp_data[29:0], rsp_valid, busy}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req0_ready", {31'd0, req0_ready}, 32'd1);
      chk("post_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
      settle();

      // Randomized traffic checked by the model.
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         req0_valid = ($urandom_range(0, 2) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         req0_data  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         req1_data  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
         rsp_ready  = ($urandom_range(0, 3) != 0);
      end
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
